// File: rtl/led_pattern_pkg.sv
// Shared definitions for the multi-channel LED pattern generator.
//   - led_mode_e : per-channel output mode encodings
//   - ramp_dir_e : direction of the BREATHE brightness ramp
//   - TAP_W      : width of the counter-tap select field
//   - clamp_tap  : limits a requested tap to the top bit of the shared counter
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } led_mode_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } ramp_dir_e;

  localparam int unsigned TAP_W = 5;

  // A tap beyond the counter width would select a bit that never toggles, so it is pinned to the
  // slowest real bit instead.
  function automatic logic [TAP_W-1:0] clamp_tap(input logic [TAP_W-1:0] tap,
                                                 input int unsigned       cnt_w);
    logic [TAP_W-1:0] res;
    if (32'(tap) >= cnt_w) begin
      res = TAP_W'(cnt_w - 1);
    end else begin
      res = tap;
    end
    return res;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds its mode/tap configuration, the BREATHE ramp state and the registered
// LED output.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_cnt          : shared free-running counter
//   i_wr_stb       : write strobe already decoded for this channel
//   i_wr_mode      : new mode (led_mode_e encoding)
//   i_wr_tap       : new counter tap (clamped here)
//   o_led          : registered LED drive
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int unsigned CNT_W    = 26,
  parameter int unsigned PWM_W    = 8,
  parameter led_mode_e   RST_MODE = MODE_OFF,
  parameter int unsigned RST_TAP  = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_wr_stb,
  input  logic [1:0]       i_wr_mode,
  input  logic [TAP_W-1:0] i_wr_tap,
  output logic             o_led
);

  localparam logic [PWM_W-1:0] LevelMax = '1;
  localparam logic [TAP_W-1:0] RstTap   = clamp_tap(TAP_W'(RST_TAP), CNT_W);

  led_mode_e        r_mode;
  logic [TAP_W-1:0] r_tap;
  logic [PWM_W-1:0] r_level;
  ramp_dir_e        r_dir;
  logic             r_prev_bit;
  logic             r_led;

  logic [TAP_W-1:0] w_new_tap;
  logic             w_tap_bit;
  logic             w_new_bit;
  logic             w_step;
  logic             w_pwm;
  logic             w_led_d;

  assign w_new_tap = clamp_tap(i_wr_tap, CNT_W);

  // Mask-and-reduce rather than a variable bit-select keeps the index width independent of CNT_W.
  assign w_tap_bit = |(i_cnt & (CNT_W'(1) << r_tap));
  assign w_new_bit = |(i_cnt & (CNT_W'(1) << w_new_tap));

  // Rising edge of the selected tap bit paces the breathe ramp.
  assign w_step = ~r_prev_bit & w_tap_bit;

  // Duty cycle over each 2^PWM_W-cycle window equals level / 2^PWM_W.
  assign w_pwm = (i_cnt[PWM_W-1:0] < r_level);

  always_comb begin
    w_led_d = 1'b0;
    case (r_mode)
      MODE_OFF:     w_led_d = 1'b0;
      MODE_ON:      w_led_d = 1'b1;
      MODE_BLINK:   w_led_d = w_tap_bit;
      MODE_BREATHE: w_led_d = w_pwm;
      default:      w_led_d = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode     <= RST_MODE;
      r_tap      <= RstTap;
      r_level    <= '0;
      r_dir      <= DirUp;
      r_prev_bit <= 1'b0;
      r_led      <= 1'b0;
    end else begin
      r_led <= w_led_d;
      if (i_wr_stb) begin
        // A write restarts the ramp and swallows any step event that coincides with it.
        r_mode     <= led_mode_e'(i_wr_mode);
        r_tap      <= w_new_tap;
        r_level    <= '0;
        r_dir      <= DirUp;
        r_prev_bit <= w_new_bit;
      end else begin
        r_prev_bit <= w_tap_bit;
        if ((r_mode == MODE_BREATHE) && w_step) begin
          case (r_dir)
            DirUp: begin
              if (r_level != LevelMax) begin
                r_level <= r_level + 1'b1;
                if (r_level == LevelMax - 1'b1) begin
                  r_dir <= DirDown;
                end
              end
            end
            DirDown: begin
              if (r_level != '0) begin
                r_level <= r_level - 1'b1;
                if (r_level == PWM_W'(1)) begin
                  r_dir <= DirUp;
                end
              end
            end
            default: r_dir <= DirUp;
          endcase
        end
      end
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator. A shared free-running counter drives NUM_CH independent
// channels, each configurable at runtime as OFF, ON, BLINK or BREATHE. Out of reset channel 0
// blinks on counter bit RESET_TAP, matching the original single-LED blinker.
//   clock, reset_n : system clock, asynchronous active-low reset
//   in_wr_en       : single-cycle configuration write strobe
//   in_wr_ch       : target channel; indices >= NUM_CH are ignored
//   in_wr_mode     : 0=OFF, 1=ON, 2=BLINK, 3=BREATHE
//   in_wr_tap      : counter bit setting blink rate / breathe step rate
//   out_leds       : registered LED outputs
//   out_tick       : high while the shared counter is 0 after wrapping
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 26,
  parameter int unsigned PWM_W     = 8,
  parameter int unsigned RESET_TAP = 24,
  parameter int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_wr_en,
  input  logic [CH_W-1:0]   in_wr_ch,
  input  logic [1:0]        in_wr_mode,
  input  logic [TAP_W-1:0]  in_wr_tap,
  output logic [NUM_CH-1:0] out_leds,
  output logic              out_tick
);

  logic [CNT_W-1:0]  r_cnt;
  logic              r_tick;
  logic              w_wr_ok;
  logic [NUM_CH-1:0] w_wr_stb;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= &r_cnt;
    end
  end

  assign out_tick = r_tick;

  // When NUM_CH is not a power of two some encodable indices have no channel behind them.
  assign w_wr_ok = in_wr_en && (32'(in_wr_ch) < NUM_CH);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam led_mode_e   ChRstMode = (g == 0) ? MODE_BLINK : MODE_OFF;
    localparam int unsigned ChRstTap  = (g == 0) ? RESET_TAP : 0;

    assign w_wr_stb[g] = w_wr_ok && (in_wr_ch == CH_W'(g));

    led_channel #(
      .CNT_W   (CNT_W),
      .PWM_W   (PWM_W),
      .RST_MODE(ChRstMode),
      .RST_TAP (ChRstTap)
    ) u_ch (
      .i_clk    (clock),
      .i_rst_n  (reset_n),
      .i_cnt    (r_cnt),
      .i_wr_stb (w_wr_stb[g]),
      .i_wr_mode(in_wr_mode),
      .i_wr_tap (in_wr_tap),
      .o_led    (out_leds[g])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen. Two instances share stimulus: A with 4 channels and
// B with 3 channels (so channel index 3 is out of range for B). A cycle-level reference model
// tracks the counter and, per channel, mode, tap and the number of breathe steps taken since the
// last write; brightness is derived from that step count as a triangle wave.
module tb_led_pattern_gen;

  localparam int unsigned CntW   = 8;
  localparam int unsigned PwmW   = 3;
  localparam int unsigned RstTap = 6;
  localparam int          CntMod = 256;
  localparam int          LvlMax = 7;
  localparam int          Period = 14;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_wr_en = 1'b0;
  logic [1:0] in_wr_ch = '0;
  logic [1:0] in_wr_mode = '0;
  logic [4:0] in_wr_tap = '0;
  logic [3:0] leds_a;
  logic       tick_a;
  logic [2:0] leds_b;
  logic       tick_b;

  always #5 clock = ~clock;

  led_pattern_gen #(
    .NUM_CH(4), .CNT_W(CntW), .PWM_W(PwmW), .RESET_TAP(RstTap)
  ) u_dut_a (
    .clock(clock), .reset_n(reset_n), .in_wr_en(in_wr_en), .in_wr_ch(in_wr_ch),
    .in_wr_mode(in_wr_mode), .in_wr_tap(in_wr_tap), .out_leds(leds_a), .out_tick(tick_a)
  );

  led_pattern_gen #(
    .NUM_CH(3), .CNT_W(CntW), .PWM_W(PwmW), .RESET_TAP(RstTap)
  ) u_dut_b (
    .clock(clock), .reset_n(reset_n), .in_wr_en(in_wr_en), .in_wr_ch(in_wr_ch),
    .in_wr_mode(in_wr_mode), .in_wr_tap(in_wr_tap), .out_leds(leds_b), .out_tick(tick_b)
  );

  // Reference model state
  int         m_cnt;
  int         m_mode  [2][4];
  int         m_tap   [2][4];
  int         m_steps [2][4];
  bit         m_prev  [2][4];
  logic [3:0] exp_leds[2];
  logic       exp_tick;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, want, $time);
    end
  endtask

  function automatic int tri_level(input int steps);
    int k;
    k = steps % Period;
    return (k <= LvlMax) ? k : Period - k;
  endfunction

  function automatic int bit_of(input int v, input int b);
    return (v >> b) & 1;
  endfunction

  task automatic model_reset();
    m_cnt    = 0;
    exp_tick = 1'b0;
    for (int n = 0; n < 2; n++) begin
      exp_leds[n] = '0;
      for (int c = 0; c < 4; c++) begin
        m_mode[n][c]  = (c == 0) ? 2 : 0;
        m_tap[n][c]   = (c == 0) ? RstTap : 0;
        m_steps[n][c] = 0;
        m_prev[n][c]  = 1'b0;
      end
    end
  endtask

  // One clock edge: outputs from the pre-edge state, then apply the write / step.
  task automatic model_edge(input bit en, input int ch, input int mode, input int tap);
    int nch;
    int b;
    int ntap;
    exp_tick = (m_cnt == CntMod - 1);
    for (int n = 0; n < 2; n++) begin
      nch = (n == 0) ? 4 : 3;
      exp_leds[n] = '0;
      for (int c = 0; c < nch; c++) begin
        b = bit_of(m_cnt, m_tap[n][c]);
        case (m_mode[n][c])
          1:       exp_leds[n][c] = 1'b1;
          2:       exp_leds[n][c] = (b != 0);
          3:       exp_leds[n][c] = ((m_cnt % 8) < tri_level(m_steps[n][c]));
          default: exp_leds[n][c] = 1'b0;
        endcase
        if (en && ch == c) begin
          ntap = (tap >= int'(CntW)) ? int'(CntW) - 1 : tap;
          m_mode[n][c]  = mode;
          m_tap[n][c]   = ntap;
          m_steps[n][c] = 0;
          m_prev[n][c]  = bit_of(m_cnt, ntap) != 0;
        end else begin
          if (m_mode[n][c] == 3 && !m_prev[n][c] && b != 0) m_steps[n][c]++;
          m_prev[n][c] = (b != 0);
        end
      end
    end
    m_cnt = (m_cnt + 1) % CntMod;
  endtask

  task automatic cycle(input bit en, input int ch, input int mode, input int tap);
    in_wr_en   = en;
    in_wr_ch   = 2'(ch);
    in_wr_mode = 2'(mode);
    in_wr_tap  = 5'(tap);
    @(posedge clock);
    model_edge(en, ch, mode, tap);
    #1;
    check_eq("leds_a", 32'(leds_a), 32'(exp_leds[0]));
    check_eq("leds_b", 32'(leds_b), 32'(exp_leds[1][2:0]));
    check_eq("tick_a", 32'(tick_a), 32'(exp_tick));
    check_eq("tick_b", 32'(tick_b), 32'(exp_tick));
    in_wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ticks;
    int tap;

    // Reset applied from time 0; flops settle on the first edge.
    model_reset();
    @(posedge clock);
    #1;
    check_eq("rst_leds_a", 32'(leds_a), 32'd0);
    check_eq("rst_leds_b", 32'(leds_b), 32'd0);
    check_eq("rst_tick", 32'(tick_a), 32'd0);
    #2 reset_n = 1'b1;

    // Free run: channel 0 blinks on cnt[6], one tick per wrap.
    n_ticks = 0;
    for (int i = 0; i < 256; i++) begin
      idle(1);
      if (tick_a) n_ticks++;
    end
    check_eq("tick_count", 32'(n_ticks), 32'd1);

    // ON then OFF on channel 2: visible two edges after the write.
    cycle(1'b1, 2, 1, 0);
    check_eq("on_t1", 32'(leds_a[2]), 32'd0);
    idle(1);
    check_eq("on_t2", 32'(leds_a[2]), 32'd1);
    idle(3);
    cycle(1'b1, 2, 0, 0);
    check_eq("off_t1", 32'(leds_a[2]), 32'd1);
    idle(1);
    check_eq("off_t2", 32'(leds_a[2]), 32'd0);

    // Breathe on channel 1 with tap 3 for more than a full triangle.
    cycle(1'b1, 1, 3, 3);
    idle(300);

    // Write coinciding with a step event (cnt[3] rising as cnt goes 7 -> 8).
    for (int k = 0; k < 16 && (m_cnt % 16) != 8; k++) idle(1);
    cycle(1'b1, 1, 3, 3);
    for (int k = 0; k < 15; k++) begin
      idle(1);
      check_eq("wr_step_lvl0", 32'(leds_a[1]), 32'd0);
    end
    idle(60);

    // Tap clamp (20 -> 7) and an index that exists only in instance A.
    cycle(1'b1, 3, 2, 20);
    idle(300);
    cycle(1'b1, 3, 1, 0);
    idle(1);
    check_eq("ch3_on_a", 32'(leds_a[3]), 32'd1);
    idle(4);

    // Randomised writes, biased towards fast taps so ramps actually move.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        tap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4);
        cycle(1'b1, $urandom_range(0, 3), $urandom_range(0, 3), tap);
      end else begin
        idle(1);
      end
    end

    // Asynchronous reset in the middle of a ramp.
    cycle(1'b1, 1, 3, 0);
    cycle(1'b1, 2, 1, 0);
    idle(37);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("async_leds_a", 32'(leds_a), 32'd0);
    check_eq("async_leds_b", 32'(leds_b), 32'd0);
    check_eq("async_tick", 32'(tick_a), 32'd0);
    @(posedge clock);
    #1;
    check_eq("held_leds_a", 32'(leds_a), 32'd0);
    #2 reset_n = 1'b1;

    n_ticks = 0;
    for (int i = 0; i < 300; i++) begin
      idle(1);
      if (tick_a) n_ticks++;
    end
    check_eq("tick_count_post", 32'(n_ticks), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
